dmem_arbiter: RTL and testbench

//  Two-requester arbiter and access sequencer in front of data_memory.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arb_rr.sv | 17 +
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, requester IDs
// and the address fault rule.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_DMA  = 1'b1;

   // Misaligned word access, or a byte address beyond the end of the memory.
   function automatic logic addr_fault(input logic [31:0] addr, input logic [32:0] limit);
      return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
   endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin pick: a lone valid requester wins, a tie goes to prio_i.
module rr_arbiter2 (
   input  logic [1:0] valid_i,
   input  logic       prio_i,
   input  logic       enable_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = 2'b00;
      if (enable_i) begin
         if (valid_i == 2'b11) grant_o = prio_i ? 2'b10 : 2'b01;
         else                  grant_o = valid_i;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of data_memory (IDLE->ACCESS->RESP).
// Define DMEM_ARB_FAULT_EN to enable the misaligned/out-of-range access check.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 1024,
   parameter int unsigned PRIO_INIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1; valid and its payload stay stable until then, ready is combinational.
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_we,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_rdata,
   output logic        rsp0_err,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_we,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_rdata,
   output logic        rsp1_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output state_e      dbg_state_o,
   output logic        dbg_prio_o
);

`ifdef DMEM_ARB_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH) * 33'd4;

   state_e      state_q, state_d;
   logic        prio_q, prio_d;
   logic [1:0]  grant;
   logic        accept;
   logic        win_id, win_we, win_fault;
   logic [31:0] win_addr, win_wdata;
   logic        cmd_id_q, cmd_we_q, cmd_fault_q;
   logic [31:0] mem_addr_q, mem_wdata_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;
   logic        rsp_hs;
   logic        mem_go;

   rr_arbiter2 u_rr (
      .valid_i  ({req1_valid, req0_valid}),
      .prio_i   (prio_q),
      .enable_i ((state_q == ST_IDLE) && !rst),
      .grant_o  (grant)
   );

   assign accept    = |grant;
   assign win_id    = grant[1];
   assign win_we    = win_id ? req1_we    : req0_we;
   assign win_addr  = win_id ? req1_addr  : req0_addr;
   assign win_wdata = win_id ? req1_wdata : req0_wdata;
   assign win_fault = FAULT_EN && addr_fault(win_addr, ADDR_LIMIT);
   assign rsp_hs    = (cmd_id_q == REQ_DMA) ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_ACCESS;
               prio_d  = ~win_id;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP:   if (rsp_hs) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // The command registers double as the memory address/data outputs, so they
   // change only on accept and hold their value through RESP and IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         prio_q      <= 1'(PRIO_INIT);
         cmd_id_q    <= REQ_CORE;
         cmd_we_q    <= 1'b0;
         cmd_fault_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         if (accept) begin
            cmd_id_q    <= win_id;
            cmd_we_q    <= win_we;
            cmd_fault_q <= win_fault;
            mem_addr_q  <= win_addr;
            mem_wdata_q <= win_wdata;
         end
         if (state_q == ST_ACCESS) begin
            rsp_rdata_q <= (cmd_we_q || cmd_fault_q) ? '0 : mem_rdata;
            rsp_err_q   <= cmd_fault_q;
         end
      end
   end

   // Strobes are gated by rst so a store caught mid-access never reaches memory.
   assign mem_go     = (state_q == ST_ACCESS) && !cmd_fault_q && !rst;
   assign mem_read   = mem_go && !cmd_we_q;
   assign mem_write  = mem_go && cmd_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   assign rsp0_valid = (state_q == ST_RESP) && (cmd_id_q == REQ_CORE);
   assign rsp1_valid = (state_q == ST_RESP) && (cmd_id_q == REQ_DMA);
   assign rsp0_rdata = rsp0_valid ? rsp_rdata_q : '0;
   assign rsp1_rdata = rsp1_valid ? rsp_rdata_q : '0;
   assign rsp0_err   = rsp0_valid && rsp_err_q;
   assign rsp1_err   = rsp1_valid && rsp_err_q;

   assign dbg_state_o = state_q;
   assign dbg_prio_o  = prio_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of arbitration, timing and memory contents.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int          DEPTH = 1024;
   localparam int unsigned PINIT = 0;

   typedef struct packed {
      logic        id;
      logic        err;
      logic [31:0] rdata;
      logic        we;
      logic [9:0]  idx;
      logic [31:0] wdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_we;
   logic [31:0] req0_addr, req0_wdata;
   logic        rsp0_valid, rsp0_ready, rsp0_err;
   logic [31:0] rsp0_rdata;
   logic        req1_valid, req1_ready, req1_we;
   logic [31:0] req1_addr, req1_wdata;
   logic        rsp1_valid, rsp1_ready, rsp1_err;
   logic [31:0] rsp1_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   state_e      dbg_state;
   logic        dbg_prio;

   int          n_vec = 0;
   int          n_fail = 0;
   int          cyc = 0;

   logic [31:0] dmem    [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   exp_t        exp_q[$];

   logic        busy;
   int          acc_cyc;
   logic        prio_m;
   logic        cur_id, cur_we, cur_fault;
   logic [31:0] cur_addr, cur_wdata;
   logic [31:0] exp_maddr, exp_mwdata;
   logic [1:0]  m_gnt;
   logic        m_rd, m_wr;
   exp_t        m_e;

   dmem_arbiter #(.MEM_DEPTH(DEPTH), .PRIO_INIT(PINIT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .dbg_state_o(dbg_state), .dbg_prio_o(dbg_prio)
   );

   // ---------------- clock, cycle count, attached memory ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_rdata = dmem[mem_addr[11:2]];
   always @(posedge clk) if (mem_write) dmem[mem_addr[11:2]] <= mem_wdata;

   // ---------------- comparison helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic logic ref_fault(input logic [31:0] a);
`ifdef DMEM_ARB_FAULT_EN
      return (a % 4 != 0) || (64'(a) >= 64'(DEPTH) * 4);
`else
      return (a == 32'h0) && (a != 32'h0);
`endif
   endfunction

   // ---------------- reference model: arbitration, timing, expected data ----------------
   always @(negedge clk) begin
      if (rst) begin
         busy       = 1'b0;
         prio_m     = 1'(PINIT);
         exp_maddr  = '0;
         exp_mwdata = '0;
         exp_q.delete();
      end else begin
         m_gnt = 2'b00;
         if (!busy) begin
            if (req0_valid && req1_valid) m_gnt = prio_m ? 2'b10 : 2'b01;
            else                          m_gnt = {req1_valid, req0_valid};
         end
         check("grant", {req1_ready, req0_ready}, m_gnt);
         m_rd = busy && (cyc == acc_cyc + 1) && !cur_we && !cur_fault;
         m_wr = busy && (cyc == acc_cyc + 1) && cur_we && !cur_fault;
         check("mem_read", mem_read, m_rd);
         check("mem_write", mem_write, m_wr);
         check("mem_addr", mem_addr, exp_maddr);
         check("mem_wdata", mem_wdata, exp_mwdata);
         check("rsp0_valid", rsp0_valid, busy && (cyc >= acc_cyc + 2) && !cur_id);
         check("rsp1_valid", rsp1_valid, busy && (cyc >= acc_cyc + 2) && cur_id);
         if (busy && (cyc >= acc_cyc + 2) && (cur_id ? rsp1_ready : rsp0_ready)) busy = 1'b0;
         if (m_gnt != 2'b00) begin
            cur_id     = m_gnt[1];
            cur_we     = cur_id ? req1_we : req0_we;
            cur_addr   = cur_id ? req1_addr : req0_addr;
            cur_wdata  = cur_id ? req1_wdata : req0_wdata;
            cur_fault  = ref_fault(cur_addr);
            busy       = 1'b1;
            acc_cyc    = cyc;
            prio_m     = !cur_id;
            exp_maddr  = cur_addr;
            exp_mwdata = cur_wdata;
            m_e.id     = cur_id;
            m_e.err    = cur_fault;
            m_e.we     = cur_we;
            m_e.idx    = 10'((cur_addr >> 2) % DEPTH);
            m_e.wdata  = cur_wdata;
            m_e.rdata  = (cur_we || cur_fault) ? 32'h0 : ref_mem[m_e.idx];
            exp_q.push_back(m_e);
         end
      end
   end

   // ---------------- scoreboard: compare every presented response ----------------
   task automatic sb_check(input logic id, input logic rdy, input logic [31:0] rd, input logic er);
      exp_t e;
      if (exp_q.size() == 0) begin
         fail_now("rsp_unexpected");
         return;
      end
      e = exp_q[0];
      check("rsp_id", id, e.id);
      check("rsp_rdata", rd, e.rdata);
      check("rsp_err", er, e.err);
      if (rdy) begin
         void'(exp_q.pop_front());
         if (e.we && !e.err) ref_mem[e.idx] = e.wdata;
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rsp0_valid) sb_check(1'b0, rsp0_ready, rsp0_rdata, rsp0_err);
         if (rsp1_valid) sb_check(1'b1, rsp1_ready, rsp1_rdata, rsp1_err);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
      end
   endtask

   task automatic step();
      logic g0, g1;
      @(negedge clk);
      g0 = req0_valid && req0_ready;
      g1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (g0) req0_valid = 1'b0;
      if (g1) req1_valid = 1'b0;
   endtask

   task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
      drive(p, we, a, d);
      for (int k = 0; k < 40 && (p == 0 ? req0_valid : req1_valid); k++) step();
      if (p == 0 ? req0_valid : req1_valid) begin
         fail_now("issue_timeout");
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
   endtask

   task automatic settle();
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      for (int k = 0; k < 80 && (req0_valid || req1_valid || busy); k++) step();
      if (req0_valid || req1_valid || busy) fail_now("settle_timeout");
   endtask

   task automatic new_req(input int p);
      logic        we;
      logic [31:0] a, d;
      int          r;
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      r  = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 8) a = $urandom;
      else             a = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      drive(p, we, a, d);
   endtask

   task automatic run_random(input int cycles, input int vrate, input int rrate);
      for (int c = 0; c < cycles; c++) begin
         step();
         if (!req0_valid && $urandom_range(0, 99) < vrate) new_req(0);
         if (!req1_valid && $urandom_range(0, 99) < vrate) new_req(1);
         rsp0_ready = ($urandom_range(0, 99) < rrate);
         rsp1_ready = ($urandom_range(0, 99) < rrate);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         dmem[i]    = $urandom;
         ref_mem[i] = dmem[i];
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", dbg_state, ST_IDLE);
      check("reset_prio", dbg_prio, 1'(PINIT));
      check("reset_ready", {req1_ready, req0_ready}, 2'b00);
      check("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
      check("reset_rsp_data", {rsp1_rdata, rsp0_rdata}, 64'h0);
      check("reset_rsp_err", {rsp1_err, rsp0_err}, 2'b00);
      check("reset_mem_strobe", {mem_write, mem_read}, 2'b00);
      check("reset_mem_addr", mem_addr, 32'h0);
      check("reset_mem_wdata", mem_wdata, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // core load of a known word
      dmem[4]    = 32'hDEADBEEF;
      ref_mem[4] = 32'hDEADBEEF;
      issue(0, 1'b0, 32'h10, 32'h0);
      settle();

      // DMA store, then core load of the same word
      issue(1, 1'b1, 32'h20, 32'h12345678);
      settle();
      issue(0, 1'b0, 32'h20, 32'h0);
      settle();

      // both requesters saturating with responses always accepted
      run_random(30, 100, 100);
      settle();

      // response back-pressure while the other port waits
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      drive(0, 1'b0, 32'h08, 32'h0);
      drive(1, 1'b0, 32'h0C, 32'h0);
      repeat (8) step();
      settle();

      // reset during the access cycle of a core store
      issue(0, 1'b1, 32'h40, 32'hCAFE0001);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mem_write", mem_write, 1'b0);
      check("rst_mem_read", mem_read, 1'b0);
      check("rst_ready", {req1_ready, req0_ready}, 2'b00);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_prio", dbg_prio, 1'(PINIT));
      check("post_rst_state", dbg_state, ST_IDLE);
      @(posedge clk);
      #1;
      drive(0, 1'b0, 32'h40, 32'h0);
      drive(1, 1'b0, 32'h44, 32'h0);
      settle();

      // misaligned address beyond the memory
      issue(0, 1'b0, 32'h1002, 32'h0);
      settle();

      run_random(600, 60, 70);
      settle();
      run_random(200, 100, 100);
      settle();

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
      if (exp_q.size() != 0) fail_now("drain");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
